music_snapshot_framer: RTL and testbench
========================================

Name: music_snapshot_framer

Overview:
Parametrised front-end framer for the MUSIC DOA pipeline. It sits between the N-channel ADC/IQ stream and the covariance stage. It cuts the continuous `idata_valid` stream into frames of exactly SAMPLES_NUM snapshots, aligned to stream start. It holds off new frames while the core is busy, aborts frames on stream gaps, and counts dropped samples. It generalises the fixed 4-channel, 512-sample feed to any channel count and frame length, and adds gap detection and frame accounting.

Parameters:
- N, 4, number of array channels.
- DATA_WIDTH, 16, signed width of each I or Q component.
- SAMPLES_NUM, 512, snapshots per frame; must be ≥2.
- GAP_TIMEOUT, 16, consecutive idle cycles inside a frame that abort it; must be ≥1.
- SYNC_ON_EDGE, 1, 1 = a frame starts only on a 0→1 edge of `idata_valid`; 0 = a frame starts on any valid sample.
- CNT_WIDTH, 16, width of the frame and drop counters.

Ports:
- iclk, input, 1, clock.
- irst_n, input, 1, reset; asynchronous, active-low.
- idata_valid, input, 1, input snapshot valid.
- idata_iq, input, 2*N*DATA_WIDTH, packed snapshot. Channel k: I at bits [(2k+1)*DW-1 : 2k*DW], Q at bits [(2k+2)*DW-1 : (2k+1)*DW].
- icore_done, input, 1, one-cycle pulse from the DOA core when its result is ready.
- odata_valid, output, 1, forwarded snapshot valid.
- odata_iq, output, 2*N*DATA_WIDTH, forwarded snapshot, registered copy of `idata_iq`.
- osof, output, 1, high with the first snapshot of a frame.
- oeof, output, 1, high with the SAMPLES_NUM-th snapshot of a frame.
- oabort, output, 1, one-cycle pulse: the current partial frame is invalid.
- oframe_cnt, output, CNT_WIDTH, completed frames; wraps.
- odrop_cnt, output, CNT_WIDTH, input samples not forwarded; saturates at all-ones.
- ostate, output, 2, FSM state: 0 = SYNC, 1 = PASS, 2 = WAIT.

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0; state = SYNC.
  - Internal sample count = 0, gap count = 0.
  - Internal `prev_valid` = 1, so with SYNC_ON_EDGE=1 a stream already running at reset release is not entered mid-frame.
- `prev_valid` updates every cycle to `idata_valid`.
- Latency: exactly 1 cycle. A sample accepted at edge t appears on `odata_*` in cycle t+1.
- `osof`, `oeof`, `oabort` are registered and aligned with `odata_valid`. `odata_iq` holds its last value when `odata_valid` = 0.
- SYNC state:
  - Start condition: `idata_valid` = 1 AND (SYNC_ON_EDGE=0 OR `prev_valid` = 0).
  - On start: forward the sample with `osof` = 1, set count = 1, go to PASS.
  - Any other valid sample is dropped and `odrop_cnt` increments.
- PASS state:
  - Each valid sample is forwarded and count increments.
  - When the forwarded sample is number SAMPLES_NUM: `oeof` = 1, `oframe_cnt` increments, count = 0, go to WAIT.
  - Each idle cycle increments the gap count; a valid sample clears it.
  - When the gap count reaches GAP_TIMEOUT: `oabort` pulses for 1 cycle, count = 0, gap count = 0, go to SYNC. `oframe_cnt` is unchanged.
  - A valid sample arriving on the cycle that would hit the threshold wins: it is forwarded and the gap count clears.
- WAIT state (covariance, Jacobi and search running):
  - All valid samples are dropped and counted.
  - `icore_done` moves to SYNC. With SYNC_ON_EDGE=1 the next frame needs a fresh 0→1 edge.
  - A valid sample in the same cycle as `icore_done` is dropped.
- `icore_done` in SYNC or PASS is ignored.
- SAMPLES_NUM=1 is unsupported. `osof` and `oeof` are never high together.
- `oframe_cnt` wraps from all-ones to 0. `odrop_cnt` sticks at all-ones.
- Inputs are assumed synchronous to `iclk`. The sample count is $clog2(SAMPLES_NUM+1) bits wide.

Test Plan:
1. N=4, SAMPLES_NUM=8, GAP_TIMEOUT=4. Release reset with valid low, then 8 valid samples with values 1..8 → 8 outputs one cycle later; `osof` on value 1, `oeof` on value 8; `oframe_cnt` = 1; ostate = 2.
2. Continue valid high for 5 more samples while in WAIT → all dropped, `odrop_cnt` = 5. Pulse `icore_done` with valid still high → SYNC, nothing forwarded until valid goes low then high; the next sample carries `osof`.
3. Hold valid high through reset release with SYNC_ON_EDGE=1 → no forwarding and `odrop_cnt` counts every cycle. Repeat with SYNC_ON_EDGE=0 → `osof` on the first sample after release.
4. Gap abort: 3 valid samples, then valid low 4 cycles → `oabort` pulse on the 4th idle cycle, `oframe_cnt` unchanged, ostate = 0. Valid low only 3 cycles then resuming → no abort, and the frame completes at 8 samples.
5. N=8, DATA_WIDTH=12: per-channel ramp patterns → bit-exact `odata_iq`, including the sign bits of negative Q values.
6. Async reset asserted mid-frame (sample 5 of 8) → all outputs 0 immediately without waiting for a clock edge; the next frame starts cleanly with count restarting at 1.

Source files
------------

// File: rtl/music_snapshot_framer.sv
// Snapshot framer between the N-channel IQ stream and the MUSIC covariance stage.
// Cuts the valid stream into SAMPLES_NUM-snapshot frames, holds off while the core runs, aborts on gaps.
module music_snapshot_framer #(
  parameter int N            = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int SAMPLES_NUM  = 512,
  parameter int GAP_TIMEOUT  = 16,
  parameter int SYNC_ON_EDGE = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                        iclk,
  input  logic                        irst_n,
  input  logic                        idata_valid,
  input  logic [2*N*DATA_WIDTH-1:0]   idata_iq,
  input  logic                        icore_done,
  output logic                        odata_valid,
  output logic [2*N*DATA_WIDTH-1:0]   odata_iq,
  output logic                        osof,
  output logic                        oeof,
  output logic                        oabort,
  output logic [CNT_WIDTH-1:0]        oframe_cnt,
  output logic [CNT_WIDTH-1:0]        odrop_cnt,
  output logic [1:0]                  ostate
);

  localparam int IQ_W   = 2 * N * DATA_WIDTH;
  localparam int SCNT_W = $clog2(SAMPLES_NUM + 1);
  localparam int GCNT_W = $clog2(GAP_TIMEOUT + 1);

  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLES_NUM - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_TIMEOUT - 1);
  localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);
  localparam logic              EDGE_MODE = (SYNC_ON_EDGE != 0);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_PASS = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
    if (val == {CNT_WIDTH{1'b1}}) begin
      sat_inc = val;
    end else begin
      sat_inc = val + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [SCNT_W-1:0]   scnt_r;
  logic [SCNT_W-1:0]   scnt_s;
  logic [GCNT_W-1:0]   gcnt_r;
  logic [GCNT_W-1:0]   gcnt_s;
  logic                prev_valid_r;

  logic                fwd_s;
  logic                sof_s;
  logic                eof_s;
  logic                abort_s;
  logic                frame_inc_s;
  logic                drop_s;

  logic                data_valid_r;
  logic [IQ_W-1:0]     data_iq_r;
  logic                sof_r;
  logic                eof_r;
  logic                abort_r;
  logic [CNT_WIDTH-1:0] frame_cnt_r;
  logic [CNT_WIDTH-1:0] drop_cnt_r;

  // Next-state, counter and event decode for the SYNC/PASS/WAIT framer.
  always_comb begin
    state_s     = state_r;
    scnt_s      = scnt_r;
    gcnt_s      = gcnt_r;
    fwd_s       = 1'b0;
    sof_s       = 1'b0;
    eof_s       = 1'b0;
    abort_s     = 1'b0;
    frame_inc_s = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      ST_SYNC: begin
        // Reset leaves prev_valid high so a running stream is never entered mid-frame.
        if (idata_valid && (!EDGE_MODE || !prev_valid_r)) begin
          fwd_s   = 1'b1;
          sof_s   = 1'b1;
          scnt_s  = SCNT_ONE;
          gcnt_s  = {GCNT_W{1'b0}};
          state_s = ST_PASS;
        end else begin
          drop_s  = idata_valid;
        end
      end
      ST_PASS: begin
        if (idata_valid) begin
          fwd_s  = 1'b1;
          gcnt_s = {GCNT_W{1'b0}};
          if (scnt_r == SCNT_LAST) begin
            eof_s       = 1'b1;
            frame_inc_s = 1'b1;
            scnt_s      = {SCNT_W{1'b0}};
            state_s     = ST_WAIT;
          end else begin
            scnt_s      = scnt_r + SCNT_ONE;
          end
        end else if (gcnt_r == GCNT_LAST) begin
          abort_s = 1'b1;
          scnt_s  = {SCNT_W{1'b0}};
          gcnt_s  = {GCNT_W{1'b0}};
          state_s = ST_SYNC;
        end else begin
          gcnt_s  = gcnt_r + GCNT_ONE;
        end
      end
      ST_WAIT: begin
        drop_s = idata_valid;
        if (icore_done) begin
          state_s = ST_SYNC;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_SYNC;
        scnt_s  = {SCNT_W{1'b0}};
        gcnt_s  = {GCNT_W{1'b0}};
      end
    endcase
  end

  // FSM state, sample/gap counters and stream-edge history.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_r      <= ST_SYNC;
      scnt_r       <= {SCNT_W{1'b0}};
      gcnt_r       <= {GCNT_W{1'b0}};
      prev_valid_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      scnt_r       <= scnt_s;
      gcnt_r       <= gcnt_s;
      prev_valid_r <= idata_valid;
    end
  end

  // Registered forward path and frame markers, one cycle behind the input.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      data_valid_r <= 1'b0;
      data_iq_r    <= {IQ_W{1'b0}};
      sof_r        <= 1'b0;
      eof_r        <= 1'b0;
      abort_r      <= 1'b0;
    end else begin
      data_valid_r <= fwd_s;
      sof_r        <= sof_s;
      eof_r        <= eof_s;
      abort_r      <= abort_s;
      if (fwd_s) begin
        data_iq_r  <= idata_iq;
      end
    end
  end

  // Frame counter wraps; drop counter saturates.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      frame_cnt_r <= {CNT_WIDTH{1'b0}};
      drop_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      if (frame_inc_s) begin
        frame_cnt_r <= frame_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (drop_s) begin
        drop_cnt_r  <= sat_inc(drop_cnt_r);
      end
    end
  end

  assign odata_valid = data_valid_r;
  assign odata_iq    = data_iq_r;
  assign osof        = sof_r;
  assign oeof        = eof_r;
  assign oabort      = abort_r;
  assign oframe_cnt  = frame_cnt_r;
  assign odrop_cnt   = drop_cnt_r;
  assign ostate      = state_r;

endmodule

// File: tb/tb_music_snapshot_framer.sv
// Scoreboard bench: instance A (N=4, edge sync) and instance B (N=8, DW=12, level sync).
module tb_music_snapshot_framer;

  localparam int AW = 128;
  localparam int BW = 192;

  typedef struct {
    logic [BW-1:0] iq;
    logic          sof;
    logic          eof;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst_n, a_valid, a_done;
  logic [AW-1:0] a_iq;
  logic          a_ovalid, a_sof, a_eof, a_abort;
  logic [AW-1:0] a_oiq;
  logic [15:0]   a_fcnt, a_dcnt;
  logic [1:0]    a_state;

  logic          b_rst_n, b_valid, b_done;
  logic [BW-1:0] b_iq;
  logic          b_ovalid, b_sof, b_eof, b_abort;
  logic [BW-1:0] b_oiq;
  logic [15:0]   b_fcnt, b_dcnt;
  logic [1:0]    b_state;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;

  music_snapshot_framer #(.N(4), .DATA_WIDTH(16), .SAMPLES_NUM(8), .GAP_TIMEOUT(4),
                          .SYNC_ON_EDGE(1), .CNT_WIDTH(16)) dut_a (
    .iclk(clk), .irst_n(a_rst_n), .idata_valid(a_valid), .idata_iq(a_iq),
    .icore_done(a_done), .odata_valid(a_ovalid), .odata_iq(a_oiq), .osof(a_sof),
    .oeof(a_eof), .oabort(a_abort), .oframe_cnt(a_fcnt), .odrop_cnt(a_dcnt),
    .ostate(a_state));

  music_snapshot_framer #(.N(8), .DATA_WIDTH(12), .SAMPLES_NUM(8), .GAP_TIMEOUT(4),
                          .SYNC_ON_EDGE(0), .CNT_WIDTH(16)) dut_b (
    .iclk(clk), .irst_n(b_rst_n), .idata_valid(b_valid), .idata_iq(b_iq),
    .icore_done(b_done), .odata_valid(b_ovalid), .odata_iq(b_oiq), .osof(b_sof),
    .oeof(b_eof), .oabort(b_abort), .oframe_cnt(b_fcnt), .odrop_cnt(b_dcnt),
    .ostate(b_state));

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Channel k: I = k*256 + s, Q = -(k*16 + s + 1), 12-bit two's complement.
  function automatic logic [BW-1:0] pat(input int s);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[24*k +: 12]      = 12'(k*256 + s);
      v[24*k + 12 +: 12] = 12'(-(k*16 + s + 1));
    end
    return v;
  endfunction

  task automatic drive_a(input logic v, input logic [AW-1:0] d, input logic done,
                         input logic fwd, input logic sof, input logic eof);
    exp_t e;
    @(negedge clk);
    a_valid = v; a_iq = d; a_done = done;
    if (fwd) begin
      e.iq = BW'(d); e.sof = sof; e.eof = eof;
      qa.push_back(e);
    end
  endtask

  task automatic drive_b(input logic v, input logic [BW-1:0] d, input logic done,
                         input logic fwd, input logic sof, input logic eof);
    exp_t e;
    @(negedge clk);
    b_valid = v; b_iq = d; b_done = done;
    if (fwd) begin
      e.iq = d; e.sof = sof; e.eof = eof;
      qb.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (a_ovalid === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got output %0h expected none", a_oiq);
      end else begin
        ea = qa.pop_front();
        chk("a_iq", BW'(a_oiq), ea.iq);
        chk("a_sof", BW'(a_sof), BW'(ea.sof));
        chk("a_eof", BW'(a_eof), BW'(ea.eof));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_ovalid === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got output %0h expected none", b_oiq);
      end else begin
        eb = qb.pop_front();
        chk("b_iq", b_oiq, eb.iq);
        chk("b_sof", BW'(b_sof), BW'(eb.sof));
        chk("b_eof", BW'(b_eof), BW'(eb.eof));
      end
    end
  end

  initial begin
    exp_t e0;
    a_rst_n = 1'b0; a_valid = 1'b0; a_iq = '0; a_done = 1'b0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_iq = '0; b_done = 1'b0;
    #12;
    chk("a_rst_valid", BW'(a_ovalid), '0);
    chk("a_rst_fcnt", BW'(a_fcnt), '0);
    chk("a_rst_dcnt", BW'(a_dcnt), '0);
    chk("a_rst_state", BW'(a_state), '0);
    @(negedge clk); a_rst_n = 1'b1;

    // Full frame 1..8, then WAIT drops and core_done with valid held high
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) drive_a(1'b1, AW'(i), 1'b0, 1'b1, i == 1, i == 8);
    for (int i = 9; i <= 13; i++) begin
      drive_a(1'b1, AW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 9) begin
        chk("a_fcnt_frame1", BW'(a_fcnt), BW'(1));
        chk("a_state_wait", BW'(a_state), BW'(2));
      end
    end
    drive_a(1'b1, AW'(14), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("a_drop5", BW'(a_dcnt), BW'(5));
    drive_a(1'b1, AW'(15), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_state_sync_after_done", BW'(a_state), BW'(0));
    chk("a_drop6", BW'(a_dcnt), BW'(6));
    drive_a(1'b1, AW'(16), 1'b0, 1'b0, 1'b0, 1'b0);
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_drop8", BW'(a_dcnt), BW'(8));

    // Gap abort after 3 samples + 4 idle cycles
    for (int i = 1; i <= 3; i++) drive_a(1'b1, AW'(32 + i), 1'b0, 1'b1, i == 1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("a_no_abort_yet", BW'(a_abort), '0);
      chk("a_state_pass", BW'(a_state), BW'(1));
    end
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_abort_pulse", BW'(a_abort), BW'(1));
    chk("a_state_sync_abort", BW'(a_state), BW'(0));
    chk("a_fcnt_unchanged", BW'(a_fcnt), BW'(1));
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_abort_one_cycle", BW'(a_abort), '0);

    // 3-cycle gap is tolerated; frame completes
    for (int i = 1; i <= 3; i++) drive_a(1'b1, AW'(48 + i), 1'b0, 1'b1, i == 1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("a_gap3_no_abort", BW'(a_abort), '0);
    end
    for (int i = 4; i <= 8; i++) begin
      drive_a(1'b1, AW'(48 + i), 1'b0, 1'b1, 1'b0, i == 8);
      chk("a_gap3_still_pass", BW'(a_state), BW'(1));
      chk("a_gap3_no_abort2", BW'(a_abort), '0);
    end
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("a_fcnt_frame2", BW'(a_fcnt), BW'(2));
    chk("a_state_wait2", BW'(a_state), BW'(2));
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_state_sync2", BW'(a_state), BW'(0));
    chk("a_drop_still8", BW'(a_dcnt), BW'(8));

    // Async reset mid-frame at sample 5
    for (int i = 1; i <= 5; i++) drive_a(1'b1, AW'(64 + i), 1'b0, 1'b1, i == 1, 1'b0);
    @(posedge clk); #2;
    a_rst_n = 1'b0; a_valid = 1'b0;
    #1;
    chk("a_arst_valid", BW'(a_ovalid), '0);
    chk("a_arst_iq", BW'(a_oiq), '0);
    chk("a_arst_sof", BW'(a_sof), '0);
    chk("a_arst_fcnt", BW'(a_fcnt), '0);
    chk("a_arst_dcnt", BW'(a_dcnt), '0);
    chk("a_arst_state", BW'(a_state), '0);
    @(negedge clk); a_rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) drive_a(1'b1, AW'(80 + i), 1'b0, 1'b1, i == 1, i == 8);
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_fcnt_after_arst", BW'(a_fcnt), BW'(1));
    chk("a_state_after_arst", BW'(a_state), BW'(2));

    // Valid held high through reset release with edge sync: all dropped
    @(negedge clk);
    a_rst_n = 1'b0; a_valid = 1'b1; a_iq = AW'(96);
    @(negedge clk); a_rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive_a(1'b1, AW'(96 + k), 1'b0, 1'b0, 1'b0, 1'b0);
      chk("a_drop_held_valid", BW'(a_dcnt), BW'(k));
      chk("a_state_held_sync", BW'(a_state), BW'(0));
    end
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Instance B: level sync starts on first sample after release; 12-bit sign checks
    b_valid = 1'b1; b_iq = pat(0);
    e0.iq = pat(0); e0.sof = 1'b1; e0.eof = 1'b0;
    qb.push_back(e0);
    @(negedge clk); b_rst_n = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      drive_b(1'b1, pat(s), 1'b0, 1'b1, 1'b0, s == 7);
      if (s == 1) begin
        chk("b_first_sof", BW'(b_sof), BW'(1));
        chk("b_ch0_i", BW'(b_oiq[11:0]), BW'(12'h000));
        chk("b_ch0_q_neg", BW'(b_oiq[23:12]), BW'(12'hFFF));
        chk("b_ch7_i", BW'(b_oiq[179:168]), BW'(12'h700));
        chk("b_ch7_q_neg", BW'(b_oiq[191:180]), BW'(12'hF8F));
      end
    end
    drive_b(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_fcnt", BW'(b_fcnt), BW'(1));
    chk("b_state_wait", BW'(b_state), BW'(2));
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_state_sync", BW'(b_state), BW'(0));
    chk("b_hold_valid", BW'(b_ovalid), '0);
    chk("b_hold_ch0_q", BW'(b_oiq[23:12]), BW'(12'hFF8));
    chk("b_drop_none", BW'(b_dcnt), '0);

    repeat (3) @(negedge clk);
    chk("a_queue_empty", BW'(qa.size()), '0);
    chk("b_queue_empty", BW'(qb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
